rr_arb_stage_4: RTL and testbench

//  4-source round-robin arbitration stage with valid/ready handshakes and a registered output.

---
 rtl/rr_arb_stage_4_pkg.sv | 15 +
 rtl/rr_arb_stage_4_if.sv | 29 ++
 rtl/rr_arb_stage_4_pick4.sv | 26 ++
 rtl/rr_arb_stage_4.sv | 123 ++++++++++++
 tb/tb_rr_arb_stage_4.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_stage_4_pkg.sv
// Shared types for the 4-source round-robin arbitration stage.
package rr_arb_pkg;

  localparam int N_SRC = 4;

  typedef logic [1:0] src_idx_t;

  function automatic logic [N_SRC-1:0] src_onehot(input src_idx_t idx);
    logic [N_SRC-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb_stage_4_if.sv
// Handshake bundle: four valid/ready input channels merged into one output stream.
interface rr_arb_stage_4_if #(
  parameter int WIDTH = 4
);
  import rr_arb_pkg::*;

  logic [N_SRC-1:0] in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [N_SRC-1:0] in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  src_idx_t         out_src;

  // master: sources and sink (the environment around the arbiter)
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_arb_stage_4_pick4.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod 4.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  output src_idx_t         winner,
  output logic             any_valid
);

  src_idx_t idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    winner    = ptr;
    idx       = ptr;
    any_valid = |req;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = ptr + src_idx_t'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_stage_4.sv
// 4-source round-robin arbiter with a registered, pass-through-pipelined output.
// Optional per-source grant counters are built when RR_GRANT_COUNT_EN is defined.
module rr_arb_stage_4
  import rr_arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_arb_stage_4_if.slave     bus
`ifdef RR_GRANT_COUNT_EN
  ,
  output logic [COUNT_W-1:0]  grant_cnt0,
  output logic [COUNT_W-1:0]  grant_cnt1,
  output logic [COUNT_W-1:0]  grant_cnt2,
  output logic [COUNT_W-1:0]  grant_cnt3
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  src_idx_t         out_src_q,   out_src_d;
  src_idx_t         ptr_q,       ptr_d;

  src_idx_t         winner;
  logic             any_valid;
  logic             load;
  logic             grant;
  logic [WIDTH-1:0] win_data;
  logic [N_SRC-1:0] in_ready;

  rr_pick4 u_pick (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    win_data = bus.in_data0;
    case (winner)
      2'd0: win_data = bus.in_data0;
      2'd1: win_data = bus.in_data1;
      2'd2: win_data = bus.in_data2;
      2'd3: win_data = bus.in_data3;
      default: win_data = bus.in_data0;
    endcase
  end

  // The output register may take a new word when empty or draining this cycle.
  always_comb begin
    load        = !out_valid_q || bus.out_ready;
    grant       = load && any_valid;
    in_ready    = grant ? src_onehot(winner) : '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = win_data;
        out_src_d   = winner;
        ptr_d       = winner + src_idx_t'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef RR_GRANT_COUNT_EN
  logic [COUNT_W-1:0] cnt_q [N_SRC];
  logic [COUNT_W-1:0] cnt_d [N_SRC];

  // Counters wrap naturally at 2**COUNT_W.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (in_ready[i]) begin
        cnt_d[i] = cnt_q[i] + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
  assign grant_cnt2 = cnt_q[2];
  assign grant_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_rr_arb_stage_4.sv
// Directed self-checking bench for rr_arb_stage_4; counter checks built with RR_GRANT_COUNT_EN.
module tb_rr_arb_stage_4;
  import rr_arb_pkg::*;

  localparam int WIDTH = 4;
`ifdef RR_GRANT_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rr_arb_stage_4_if #(.WIDTH(WIDTH)) bus ();

`ifdef RR_GRANT_COUNT_EN
  logic [CW-1:0] gc0, gc1, gc2, gc3;
`endif

  rr_arb_stage_4 #(.WIDTH(WIDTH), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave)
`ifdef RR_GRANT_COUNT_EN
    ,
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1),
    .grant_cnt2 (gc2),
    .grant_cnt3 (gc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_data got %0h want 0", bus.out_data); end
    n_checks++;
    if (bus.out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d want 0", bus.out_src); end
    n_checks++;
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_data;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_data = WIDTH'(k % 4 + 1);
      #1;
      if (bus.in_ready !== (4'b0001 << (k % 4))) begin
        n_fail++; $display("FAIL rr_in_ready[%0d] got %b want %b", k, bus.in_ready, 4'b0001 << (k % 4));
      end
      n_checks++;
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(k % 4) || bus.out_data !== exp_data) begin
        n_fail++;
        $display("FAIL rr_out[%0d] got v=%0b src=%0d data=%0h want v=1 src=%0d data=%0h",
                 k, bus.out_valid, bus.out_src, bus.out_data, k % 4, exp_data);
      end
      n_checks++;
    end
  endtask

  task automatic test_single();
    bus.in_valid = 4'b0100;
    bus.in_data2 = 4'h5;
    #1;
    if (bus.in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_in_ready got %b want 0100", bus.in_ready); end
    n_checks++;
    tick();
    if (bus.out_data !== 4'h5 || bus.out_src !== 2'd2) begin
      n_fail++; $display("FAIL single_out got src=%0d data=%0h want src=2 data=5", bus.out_src, bus.out_data);
    end
    n_checks++;
    bus.in_data2 = 4'h3;
    bus.in_valid = 4'b1111;
    #1;
    if (bus.in_ready !== 4'b1000) begin n_fail++; $display("FAIL ptr_after_single got %b want 1000", bus.in_ready); end
    n_checks++;
    tick();
    if (bus.out_src !== 2'd3 || bus.out_data !== 4'h4) begin
      n_fail++; $display("FAIL ptr3_out got src=%0d data=%0h want src=3 data=4", bus.out_src, bus.out_data);
    end
    n_checks++;
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    #1;
    if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_in_ready got %b want 0000", bus.in_ready); end
    n_checks++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd3 || bus.out_data !== 4'h4) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v=%0b src=%0d data=%0h want v=1 src=3 data=4",
                 k, bus.out_valid, bus.out_src, bus.out_data);
      end
      n_checks++;
      #1;
      if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0000", k, bus.in_ready); end
      n_checks++;
    end
    bus.out_ready = 1'b1;
    #1;
    if (bus.in_ready !== 4'b0001) begin n_fail++; $display("FAIL unstall_ready got %b want 0001", bus.in_ready); end
    n_checks++;
    tick();
    if (bus.out_src !== 2'd0 || bus.out_data !== 4'h1) begin
      n_fail++; $display("FAIL unstall_out got src=%0d data=%0h want src=0 data=1", bus.out_src, bus.out_data);
    end
    n_checks++;
  endtask

  task automatic test_idle();
    bus.in_valid = 4'b0000;
    #1;
    if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready got %b want 0000", bus.in_ready); end
    n_checks++;
    tick();
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h1 || bus.out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_out got v=%0b src=%0d data=%0h want v=0 src=0 data=1", bus.out_valid, bus.out_src, bus.out_data);
    end
    n_checks++;
    // Empty register loads even while downstream is not ready.
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b0;
    #1;
    if (bus.in_ready !== 4'b0010) begin n_fail++; $display("FAIL empty_load_ready got %b want 0010", bus.in_ready); end
    n_checks++;
    tick();
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1 || bus.out_data !== 4'h2) begin
      n_fail++;
      $display("FAIL empty_load_out got v=%0b src=%0d data=%0h want v=1 src=1 data=2", bus.out_valid, bus.out_src, bus.out_data);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_out got v=%0b src=%0d data=%0h want v=0 src=0 data=0", bus.out_valid, bus.out_src, bus.out_data);
    end
    n_checks++;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    if (bus.in_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_scan got %b want 0001", bus.in_ready); end
    n_checks++;
    tick();
    if (bus.out_src !== 2'd0 || bus.out_data !== 4'h1) begin
      n_fail++; $display("FAIL midrst_first got src=%0d data=%0h want src=0 data=1", bus.out_src, bus.out_data);
    end
    n_checks++;
  endtask

`ifdef RR_GRANT_COUNT_EN
  task automatic test_grant_count();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (gc0 !== 2'd0 || gc1 !== 2'd0 || gc2 !== 2'd0 || gc3 !== 2'd0) begin
      n_fail++; $display("FAIL cnt_reset got %0d %0d %0d %0d want 0 0 0 0", gc0, gc1, gc2, gc3);
    end
    n_checks++;
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    bus.in_valid = 4'b0000;
    if (gc1 !== 2'd1 || gc0 !== 2'd0 || gc2 !== 2'd0 || gc3 !== 2'd0) begin
      n_fail++; $display("FAIL cnt_wrap got %0d %0d %0d %0d want 0 1 0 0", gc0, gc1, gc2, gc3);
    end
    n_checks++;
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.in_data0  = 4'h1;
    bus.in_data1  = 4'h2;
    bus.in_data2  = 4'h3;
    bus.in_data3  = 4'h4;
    bus.out_ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    test_round_robin();
    test_single();
    test_stall();
    test_idle();
    test_reset_mid();
`ifdef RR_GRANT_COUNT_EN
    test_grant_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
